// File: rtl/oam_dma_if.sv
// CPU-side strobes and DMA/OAM bus lines of the OAM DMA sequencer.
// The slave modport is the sequencer; the master modport is the surrounding system.
interface oam_dma_if;
  logic        mc_en;
  logic [15:0] cpu_a;
  logic [7:0]  cpu_d_in;
  logic        cpu_wr;
  logic        cpu_rd;
  logic [7:0]  d_out;
  logic        d_oe;
  logic        dma_active;
  logic        dma_rd;
  logic [15:0] dma_a;
  logic [7:0]  dma_rdata;
  logic        oam_wr;
  logic [7:0]  oam_a;
  logic [7:0]  oam_wd;
  logic        cpu_bus_block;
  logic        cpu_oam_block;

  modport slave (
    input  mc_en, cpu_a, cpu_d_in, cpu_wr, cpu_rd, dma_rdata,
    output d_out, d_oe, dma_active, dma_rd, dma_a,
    output oam_wr, oam_a, oam_wd, cpu_bus_block, cpu_oam_block
  );

  modport master (
    output mc_en, cpu_a, cpu_d_in, cpu_wr, cpu_rd, dma_rdata,
    input  d_out, d_oe, dma_active, dma_rd, dma_a,
    input  oam_wr, oam_a, oam_wd, cpu_bus_block, cpu_oam_block
  );
endinterface

// File: rtl/oam_dma_ctrl.sv
// OAM DMA sequencer behind FF46: copies LEN bytes from {page,00h} into OAM,
// reading byte k and writing byte k-1 in the same machine cycle.
module oam_dma_ctrl #(
  parameter int LEN         = 160,
  parameter int START_DELAY = 1
) (
  input  logic       clk,
  input  logic       nreset,
  oam_dma_if.slave   bus
);

  localparam int                 DLY_W    = (START_DELAY > 1) ? $clog2(START_DELAY + 1) : 1;
  localparam logic [7:0]         LAST_IDX = 8'(LEN - 1);
  localparam logic [DLY_W-1:0]   DLY_INIT = DLY_W'(START_DELAY);
  localparam logic [DLY_W-1:0]   DLY_ONE  = DLY_W'(1);

  typedef enum logic [1:0] {IDLE, START, XFER, DRAIN} state_t;

  state_t           state;
  logic [7:0]       src_hi;
  logic [7:0]       idx;
  logic [DLY_W-1:0] delay;
  logic             active_r;
  logic             rd_r;
  logic [7:0]       wbuf_p1;
  logic [7:0]       widx_p1;
  logic             vld_p1;
  logic             ff46_wr;

  // Echo RAM pages E0h..FFh alias down onto C0h..DFh.
  function automatic logic [7:0] eff_page(input logic [7:0] hi);
    return (hi >= 8'hE0) ? (hi - 8'h20) : hi;
  endfunction

  assign ff46_wr = bus.mc_en && bus.cpu_wr && (bus.cpu_a == 16'hFF46);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state    <= IDLE;
      src_hi   <= 8'h00;
      idx      <= 8'h00;
      delay    <= '0;
      active_r <= 1'b0;
      rd_r     <= 1'b0;
      wbuf_p1  <= 8'h00;
      widx_p1  <= 8'h00;
      vld_p1   <= 1'b0;
    end else if (bus.mc_en) begin
      if (ff46_wr) begin
        // A new page always restarts from byte 0 and drops any buffered byte.
        src_hi   <= bus.cpu_d_in;
        idx      <= 8'h00;
        delay    <= DLY_INIT;
        vld_p1   <= 1'b0;
        active_r <= 1'b1;
        if (START_DELAY == 0) begin
          state <= XFER;
          rd_r  <= 1'b1;
        end else begin
          state <= START;
          rd_r  <= 1'b0;
        end
      end else begin
        case (state)
          IDLE: ;
          START: begin
            delay <= delay - DLY_ONE;
            if (delay == DLY_ONE) begin
              state <= XFER;
              rd_r  <= 1'b1;
            end
          end
          // p0 -> p1: source byte captured for next cycle's OAM write
          XFER: begin
            wbuf_p1 <= bus.dma_rdata;
            widx_p1 <= idx;
            vld_p1  <= 1'b1;
            if (idx == LAST_IDX) begin
              state <= DRAIN;
              rd_r  <= 1'b0;
            end else begin
              idx <= idx + 8'h01;
            end
          end
          DRAIN: begin
            vld_p1   <= 1'b0;
            active_r <= 1'b0;
            state    <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.d_out         = src_hi;
  assign bus.d_oe          = bus.cpu_rd && (bus.cpu_a == 16'hFF46);
  assign bus.dma_active    = active_r;
  assign bus.dma_rd        = rd_r;
  assign bus.dma_a         = {eff_page(src_hi), idx};
  assign bus.oam_wr        = vld_p1;
  assign bus.oam_a         = widx_p1;
  assign bus.oam_wd        = wbuf_p1;
  assign bus.cpu_bus_block = active_r && (bus.cpu_a[15:8] != 8'hFF);
  assign bus.cpu_oam_block = active_r && (bus.cpu_a[15:8] == 8'hFE);

endmodule
